// File: rtl/mul8_pkg.sv
// Shared constants and state encoding for the sequential 8x8 shift-add multiplier.
// Early-exit build option: MUL8_EARLY_EXIT_EN (consumed in mul8_seq).
package mul8_pkg;

    localparam int WIDTH     = 8;
    localparam int CNT_W     = 4;
    localparam int LAST_ITER = WIDTH - 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        BUSY = S_BUSY,
        DONE = S_DONE
    } state_t;

endpackage

// File: rtl/mul8_seq_if.sv
// Operand (valid/ready) and product (valid/ready) channels of mul8_seq.
interface mul8_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p
    );

endinterface

// File: rtl/adder8.sv
// 8-bit ripple-carry adder with carry out and signed overflow flag.
module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic       ovfl
);

    logic [8:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[8];
    assign ovfl = c[8] ^ c[7];

endmodule

// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned shift-add multiplier, one partial-product add per clock.
// Define MUL8_EARLY_EXIT_EN to finish as soon as no multiplier bits remain set.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// BUSY  | one add/shift per edge, cnt counts iterations 0..7
// DONE  | product held on p with out_valid=1 until out_ready
module mul8_seq #(
    parameter int WIDTH = mul8_pkg::WIDTH,
    parameter int CNT_W = mul8_pkg::CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    mul8_seq_if.slave  bus
);

    import mul8_pkg::*;

    if (WIDTH != 8) begin : g_width_chk
        $error("mul8_seq: WIDTH must be 8, adder datapath is fixed");
    end
    if ((1 << CNT_W) <= WIDTH) begin : g_cnt_chk
        $error("mul8_seq: CNT_W too narrow for WIDTH iterations");
    end

    state_t           state, state_nxt;
    logic [7:0]       mcand, acc_hi, acc_lo;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       add_b, sum;
    logic             cout, unused_ovfl;
    logic             accept, last_iter, early_exit;
    logic [15:0]      step_acc;

    assign add_b = acc_lo[0] ? mcand : 8'h00;

    adder8 u_adder (
        .a    (acc_hi),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout),
        .ovfl (unused_ovfl)
    );

`ifdef MUL8_EARLY_EXIT_EN
    logic [7:0]       rem_mask;
    logic [CNT_W-1:0] sh_amt;

    // Multiplier bits above the one consumed this cycle; if all clear, skip the rest.
    assign rem_mask   = (8'hFF >> cnt) & 8'hFE;
    assign early_exit = (acc_lo & rem_mask) == 8'h00;
    assign sh_amt     = CNT_W'(WIDTH) - cnt;
    assign step_acc   = early_exit ? 16'({cout, sum, acc_lo} >> sh_amt)
                                   : {cout, sum, acc_lo[7:1]};
`else
    assign early_exit = 1'b0;
    assign step_acc   = {cout, sum, acc_lo[7:1]};
`endif

    assign last_iter = (cnt == CNT_W'(LAST_ITER));
    assign accept    = bus.in_valid && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (last_iter || early_exit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
        end else if (accept) begin
            mcand  <= bus.a;
            acc_hi <= '0;
            acc_lo <= bus.b;
            cnt    <= '0;
        end else if (state == BUSY) begin
            {acc_hi, acc_lo} <= step_acc;
            cnt              <= cnt + 1'b1;
        end
    end

    assign bus.p = {acc_hi, acc_lo};

endmodule

// File: tb/tb_mul8_seq.sv
// Self-checking bench for mul8_seq: directed corner cases plus random operand pairs
// against a plain a*b reference and a latency model derived from the multiplier value.
module tb_mul8_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   accepts = 0;

    always #5 clk = ~clk;

    mul8_seq_if bus ();

    mul8_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) accepts++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edges from acceptance (inclusive) until out_valid is visible.
    function automatic int exp_lat(input logic [7:0] bv);
`ifdef MUL8_EARLY_EXIT_EN
        for (int i = 7; i >= 0; i--) begin
            if (bv[i]) return 2 + i;
        end
        return 2;
`else
        return 9;
`endif
    endfunction

    // Called at a sample point (#1 after an edge) with the block expected idle.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int hold,
                          input bit keep_valid, input string tag);
        logic [15:0] exp_p;
        int          n;
        int          acc0;
        exp_p         = {8'h00, av} * {8'h00, bv};
        acc0          = accepts;
        bus.a         = av;
        bus.b         = bv;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = keep_valid;
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
        n = 1;
        while (!bus.out_valid && n < 40) begin
            check({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            n++;
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat(bv)));
        check({tag, "_p"}, 32'(bus.p), 32'(exp_p));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_p"}, 32'(bus.p), 32'(exp_p));
            check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_ret_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_ret_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_accept_count"}, 32'(accepts - acc0), 32'd1);
    endtask

    initial begin
        logic [7:0] ra, rb;
        int         n;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_p", 32'(bus.p), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op(8'hFF, 8'hFF, 0, 1'b0, "ff_ff");
        run_op(8'h0D, 8'h00, 0, 1'b0, "zero_b");
        run_op(8'h00, 8'hB7, 0, 1'b0, "zero_a");
        run_op(8'h80, 8'h80, 0, 1'b0, "80_80");
        run_op(8'hFF, 8'h80, 0, 1'b0, "ff_80");
        run_op(8'h12, 8'h34, 5, 1'b0, "hold");

        // Reset in the middle of BUSY.
        bus.a = 8'hAA; bus.b = 8'h55; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_busy_p", 32'(bus.p), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_op(8'h03, 8'h07, 0, 1'b0, "after_rst");

        // Reset while the product is waiting in DONE.
        bus.a = 8'hC3; bus.b = 8'h9E; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_done_pre_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_done_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_done_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;

        // in_valid held high across four random pairs; junk operands while busy.
        for (int k = 0; k < 4; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, 0, 1'b1, "b2b");
        end
        bus.in_valid = 1'b0;

        for (int k = 0; k < 8; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, int'($urandom_range(0, 3)), 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
